// File: rtl/tb_trace_checker.sv
// Trace checker: queues expected CPU bus cycles and compares observed cycles against the head.
// Optional macro TB_TRACE_CHECKER_HALT_EN freezes checking after the first failure.
module tb_trace_checker #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [15:0]      exp_addr,
   input  logic [7:0]       exp_data,
   input  logic             exp_we,
   input  logic             exp_dcare,
   input  logic             obs_valid,
   input  logic [15:0]      obs_addr,
   input  logic [7:0]       obs_data,
   input  logic             obs_we,
   output logic             chk_pass,
   output logic             chk_fail,
   output logic             underrun,
   output logic [15:0]      fail_addr,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             empty,
   output logic             halted
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic        dcare;
      logic [7:0]  data;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_cnt;
   logic             r_pass;
   logic             r_fail;
   logic             r_underrun;
   logic             r_fail_seen;
   logic [15:0]      r_fail_addr;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;

   entry_t w_head;
   logic   w_full;
   logic   w_empty;
   logic   w_obs;
   logic   w_push;
   logic   w_pop;
   logic   w_match;
   logic   w_pass;
   logic   w_fail;

   assign w_full  = (r_cnt == FULL_CNT);
   assign w_empty = (r_cnt == '0);
   assign w_head  = r_mem[r_rptr];
   assign w_obs   = obs_valid && !halted;
   // Fullness is judged before any same-cycle pop, so a full FIFO refuses the push.
   assign w_push  = exp_valid && !w_full;
   assign w_pop   = w_obs && !w_empty;
   assign w_match = (obs_addr == w_head.addr) && (obs_we == w_head.we) &&
                    (w_head.dcare || (obs_data == w_head.data));
   assign w_pass  = w_pop && w_match;
   assign w_fail  = w_obs && (w_empty || !w_match);

   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wptr] <= '{addr: exp_addr, we: exp_we, dcare: exp_dcare, data: exp_data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_underrun  <= 1'b0;
         r_fail_seen <= 1'b0;
         r_fail_addr <= '0;
         r_pass_cnt  <= '0;
         r_fail_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + CW'(1);
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - CW'(1);
         end
         r_pass <= w_pass;
         r_fail <= w_fail;
         if (w_obs && w_empty) r_underrun <= 1'b1;
         if (w_fail && !r_fail_seen) begin
            r_fail_seen <= 1'b1;
            r_fail_addr <= obs_addr;
         end
         if (w_pass && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
         if (w_fail && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      end
   end

`ifdef TB_TRACE_CHECKER_HALT_EN
   logic r_halted;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_halted <= 1'b0;
      end else if (w_fail) begin
         r_halted <= 1'b1;
      end
   end
   assign halted = r_halted;
`else
   assign halted = 1'b0;
`endif

   assign exp_ready = !w_full;
   assign empty     = w_empty;
   assign chk_pass  = r_pass;
   assign chk_fail  = r_fail;
   assign underrun  = r_underrun;
   assign fail_addr = r_fail_addr;
   assign pass_cnt  = r_pass_cnt;
   assign fail_cnt  = r_fail_cnt;

endmodule
